// File: rtl/keypad_emulator.sv
// keypad_emulator: scanned 4x4 keypad model with optional contact bounce.
// Ports: int_osc clock, reset async active-high, row in (active-low),
//   col out (active-low, registered), key/hold_cycles/key_valid request,
//   key_ready (high in IDLE), done (one-clock pulse at end of sequence).
// Macro KEYPAD_EMU_BOUNCE_EN enables the PRESS/RELEASE bounce phases;
//   without it the contact closes and opens cleanly.
module keypad_emulator #(
   parameter int BOUNCE_CYCLES = 48,
   parameter int BOUNCE_PERIOD = 5,
   parameter int GAP_CYCLES    = 16
) (
   input  logic        int_osc,
   input  logic        reset,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic [3:0]  key,
   input  logic [15:0] hold_cycles,
   input  logic        key_valid,
   output logic        key_ready,
   output logic        done
);

   localparam int WB = $clog2(BOUNCE_CYCLES + 1);
   localparam int WP = $clog2(BOUNCE_PERIOD + 1);
   localparam int WG = $clog2(GAP_CYCLES + 1);
   // wide enough for any duration the counter is ever loaded with
   localparam int CW = (WB > 16 || WP > 16 || WG > 16) ? 32 : 16;

   localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_BOUNCE,
      HELD,
      RELEASE_BOUNCE,
      GAP
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            contact;
   logic [3:0]      key_q;
   logic [15:0]     hold_eff;

   assign hold_eff  = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
   assign key_ready = (state == IDLE);

`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam logic [CW-1:0] BNC_LD = CW'(BOUNCE_CYCLES - 1);
   localparam logic [WP-1:0] PER_LD = WP'(BOUNCE_PERIOD - 1);

   logic [15:0]   hold_q;
   logic [WP-1:0] tog;
   // bph = 0 : contact in its "entry" position of the bounce phase
   logic          bph;
`endif

   always_ff @(posedge int_osc or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         contact <= 1'b0;
         col     <= 4'hF;
         done    <= 1'b0;
         key_q   <= 4'h0;
`ifdef KEYPAD_EMU_BOUNCE_EN
         hold_q  <= 16'h0;
         tog     <= '0;
         bph     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         // column sense follows the row drive with one clock of latency
         if (contact && !row[key_q[3:2]])
            col <= ~(4'b0001 << key_q[1:0]);
         else
            col <= 4'hF;

`ifdef KEYPAD_EMU_BOUNCE_EN
         if (state == PRESS_BOUNCE || state == RELEASE_BOUNCE) begin
            if (tog == '0) begin
               tog <= PER_LD;
               bph <= ~bph;
            end else begin
               tog <= tog - 1'b1;
            end
         end
`endif

         unique case (state)
            IDLE: begin
               contact <= 1'b0;
               if (key_valid) begin
                  key_q <= key;
`ifdef KEYPAD_EMU_BOUNCE_EN
                  hold_q <= hold_eff;
                  state  <= PRESS_BOUNCE;
                  cnt    <= BNC_LD;
                  tog    <= PER_LD;
                  bph    <= 1'b0;
`else
                  state  <= HELD;
                  cnt    <= CW'(hold_eff - 16'd1);
`endif
               end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            PRESS_BOUNCE: begin
               contact <= ~bph;
               if (cnt == '0) begin
                  state <= HELD;
                  cnt   <= CW'(hold_q - 16'd1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`endif
            HELD: begin
               contact <= 1'b1;
               if (cnt == '0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                  state <= RELEASE_BOUNCE;
                  cnt   <= BNC_LD;
                  tog   <= PER_LD;
                  bph   <= 1'b0;
`else
                  state <= GAP;
                  cnt   <= GAP_LD;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            RELEASE_BOUNCE: begin
               contact <= bph;
               if (cnt == '0) begin
                  state <= GAP;
                  cnt   <= GAP_LD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`endif
            // GAP is loaded with the full count because the contact
            // register opens one clock after the state changes
            GAP: begin
               contact <= 1'b0;
               if (cnt == '0) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               contact <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed and random presses against a
// timeline reference model of the keypad contact and handshake.
module tb_keypad_emulator;

   localparam int BC = 10;
   localparam int BP = 2;
   localparam int G  = 16;

   logic        int_osc = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row = 4'hF;
   logic [3:0]  key = 4'h0;
   logic [15:0] hold_cycles = 16'd0;
   logic        key_valid = 1'b0;
   logic [3:0]  col;
   logic        key_ready;
   logic        done;

   always #5 int_osc = ~int_osc;

   keypad_emulator #(
      .BOUNCE_CYCLES(BC),
      .BOUNCE_PERIOD(BP),
      .GAP_CYCLES(G)
   ) dut (
      .int_osc(int_osc),
      .reset(reset),
      .row(row),
      .col(col),
      .key(key),
      .hold_cycles(hold_cycles),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .done(done)
   );

   int n_chk = 0;
   int n_pass = 0;

   // reference model: press timeline relative to the accept edge
   int         cyc = 0;
   bit         m_busy = 0;
   int         m_n = 0;
   logic [3:0] m_key = 4'h0;
   int         m_h = 1;
   bit         m_contact = 0;
   int         n_done = 0;
   int         last_done = -1;
   int         last_acc = -1;
   int         n_closed = 0;

   // contact state after edge t of a press (t = 0 is the accept edge)
   function automatic bit win(input int t, input int h);
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (t >= 1 && t <= BC) return ((t - 1) / BP) % 2 == 0;
      if (t > BC && t <= BC + h) return 1'b1;
      if (t > BC + h && t <= 2 * BC + h)
         return ((t - BC - h - 1) / BP) % 2 == 1;
      return 1'b0;
`else
      return t >= 1 && t <= h;
`endif
   endfunction

   function automatic int tot(input int h);
`ifdef KEYPAD_EMU_BOUNCE_EN
      return 2 * BC + h + 1 + G;
`else
      return h + 1 + G;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      logic [3:0] e_col;
      bit         e_done;
      @(posedge int_osc);
      cyc++;
      if (m_contact && row[m_key[3:2]] == 1'b0)
         e_col = ~(4'b0001 << m_key[1:0]);
      else
         e_col = 4'hF;
      e_done = 0;
      if (!m_busy && key_valid) begin
         m_busy = 1;
         m_n = cyc;
         m_key = key;
         m_h = (hold_cycles == 16'd0) ? 1 : int'(hold_cycles);
         last_acc = cyc;
      end else if (m_busy && cyc - m_n == tot(m_h)) begin
         m_busy = 0;
         e_done = 1;
      end
      m_contact = m_busy && win(cyc - m_n, m_h);
      @(negedge int_osc);
      chk("col", col, e_col);
      chk("done", done, e_done);
      chk("key_ready", key_ready, !m_busy);
      if (done) begin
         n_done++;
         last_done = cyc;
      end
      if (col != 4'hF) n_closed++;
   endtask

   task automatic run_idle(input int lim);
      int k = 0;
      while ((m_busy || !key_ready) && k < lim) begin
         tick();
         k++;
      end
      chk("idle_bound", k < lim, 1);
   endtask

   task automatic press(input logic [3:0] k, input logic [15:0] h);
      key = k;
      hold_cycles = h;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   initial begin
      int acc_n;
      int exp_closed;

      // reset state
      @(negedge int_osc);
      chk("rst_col", col, 4'hF);
      chk("rst_ready", key_ready, 1);
      chk("rst_done", done, 0);
      @(negedge int_osc);
      reset = 1'b0;

      // key 6, hold 10, row 1101
      row = 4'b1101;
      n_done = 0;
      press(4'h6, 16'd10);
      acc_n = last_acc;
      run_idle(200);
      chk("done_edge", last_done - acc_n, tot(10));
      chk("done_cnt1", n_done, 1);

      // row scanned one per clock during the press
      row = 4'hF;
      press(4'h6, 16'd12);
      for (int i = 0; i < 40 && m_busy; i++) begin
         case (i % 4)
            0: row = 4'b1110;
            1: row = 4'b1101;
            2: row = 4'b1011;
            default: row = 4'b0111;
         endcase
         tick();
      end
      run_idle(200);

      // request during HELD is ignored
      row = 4'b1101;
      n_done = 0;
      press(4'h6, 16'd8);
      repeat (3) tick();
      key = 4'hF;
      key_valid = 1'b1;
      repeat (4) tick();
      key_valid = 1'b0;
      run_idle(200);
      chk("done_cnt_ign", n_done, 1);

      // reset mid-HELD abandons the press
      n_done = 0;
      press(4'h6, 16'd10);
      repeat (4) tick();
      #2 reset = 1'b1;
      #1;
      chk("arst_col", col, 4'hF);
      chk("arst_ready", key_ready, 1);
      chk("arst_done", done, 0);
      m_busy = 0;
      m_contact = 0;
      m_key = 4'h0;
      repeat (2) begin
         @(negedge int_osc);
         chk("rst_hold_col", col, 4'hF);
      end
      reset = 1'b0;
      repeat (3) tick();
      chk("rst_no_done", n_done, 0);

      // hold 0 acts as one clock
      row = 4'b1110;
      n_closed = 0;
      press(4'h3, 16'd0);
      run_idle(200);
      exp_closed = 0;
      for (int t = 0; t <= tot(1); t++)
         if (win(t, 1)) exp_closed++;
      chk("hold0_closed", n_closed, exp_closed);

      // back-to-back with key_valid held high
      row = 4'b1011;
      key = 4'h9;
      hold_cycles = 16'd2;
      key_valid = 1'b1;
      tick();
      acc_n = last_acc;
      last_done = -1;
      for (int i = 0; i < 200 && last_done < 0; i++) tick();
      chk("b2b_ready", key_ready, 1);
      tick();
      key_valid = 1'b0;
      chk("b2b_acc", last_acc, last_done + 1);
      chk("b2b_first", last_done - acc_n, tot(2));
      run_idle(200);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(1, 0) == 1)
            row = ~(4'b0001 << $urandom_range(3, 0));
         else
            row = 4'($urandom_range(15, 0));
         key = 4'($urandom_range(15, 0));
         hold_cycles = 16'($urandom_range(6, 0));
         key_valid = ($urandom_range(5, 0) == 0);
         tick();
      end
      key_valid = 1'b0;
      run_idle(200);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
